// File: rtl/spmp_csr_regs_pkg.sv
// spmp_csr_regs_pkg: SPMP CSR types, address constants and WARL masks
package spmp_csr_regs_pkg;
    localparam int SPMP_N_ENTRIES = 64;
    localparam int SPMP_AW = 54;
    localparam logic [11:0] CSR_SPMPCFG0 = 12'h1A0;
    localparam logic [11:0] CSR_SPMPADDR0 = 12'h1B0;
    localparam logic [7:0] SPMPCFG_RSVD_MASK = 8'h60;
    typedef enum logic [1:0] {PRIV_U = 2'd0, PRIV_S = 2'd1, PRIV_M = 2'd3} priv_lvl_t;
    typedef enum logic [1:0] {A_OFF, A_TOR, A_NA4, A_NAPOT} spmp_amode_t;
    typedef struct packed {
        logic        s_mode;
        logic [1:0]  reserved;
        spmp_amode_t addr_mode;
        logic [2:0]  access_perm;
    } spmpcfg_t;
    typedef logic [SPMP_AW-1:0] spmpaddr_t;
    typedef enum logic [1:0] {IDLE, RESP, FLUSH} state_t;
endpackage

// File: rtl/spmp_cfg_legalize.sv
// spmp_cfg_legalize: WARL legalisation of one spmpcfg entry byte and one spmpaddr word
module spmp_cfg_legalize
    import spmp_csr_regs_pkg::*;
#(
    parameter int PLEN = 56
) (
    input  logic [7:0] i_cfg,
    input  spmpaddr_t  i_addr,
    output spmpcfg_t   o_cfg,
    output spmpaddr_t  o_addr
);
    localparam spmpaddr_t ADDR_MASK = {SPMP_AW{1'b1}} >> (SPMP_AW - (PLEN - 2));
    assign o_cfg = spmpcfg_t'(i_cfg & ~SPMPCFG_RSVD_MASK);
    assign o_addr = i_addr & ADDR_MASK;
endmodule

// File: rtl/spmp_csr_regs.sv
// spmp_csr_regs: SPMP spmpcfg/spmpaddr CSR file with WARL writes and post-change flush handshake
module spmp_csr_regs
    import spmp_csr_regs_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int PLEN = 56,
    parameter int NR_ENTRIES = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                csr_req_valid_i,
    output logic                                csr_req_ready_o,
    input  logic                                csr_we_i,
    input  logic [11:0]                         csr_addr_i,
    input  logic [XLEN-1:0]                     csr_wdata_i,
    input  priv_lvl_t                           priv_lvl_i,
    output logic                                csr_rsp_valid_o,
    output logic [XLEN-1:0]                     csr_rdata_o,
    output logic                                csr_illegal_o,
    output spmpcfg_t  [SPMP_N_ENTRIES-1:0]      spmpcfg_o,
    output spmpaddr_t [SPMP_N_ENTRIES-1:0]      spmpaddr_o,
    output logic                                flush_req_o,
    input  logic                                flush_ack_i
);
    localparam int NB = XLEN / 8;
    state_t          r_state, w_state_nxt;
    spmpcfg_t        r_cfg [SPMP_N_ENTRIES];
    spmpaddr_t       r_addr [SPMP_N_ENTRIES];
    logic [XLEN-1:0] r_rdata, w_rdata;
    logic            r_illegal, r_chg, w_chg, w_accept, w_is_cfg, w_is_addr, w_illegal, w_aidx_ok;
    logic [5:0]      w_aidx;
    logic [6:0]      w_ent [NB];
    logic [NB-1:0]   w_ent_ok;
    spmpcfg_t        w_leg_cfg [NB];
    spmpaddr_t       w_leg_addr [NB];

    assign csr_req_ready_o = rst_ni && r_state == IDLE;
    assign csr_rsp_valid_o = r_state == RESP;
    assign flush_req_o = r_state == FLUSH;
    assign csr_rdata_o = r_rdata;
    assign csr_illegal_o = r_illegal;
    assign w_accept = csr_req_valid_i && csr_req_ready_o;
    assign w_is_cfg = csr_addr_i[11:4] == CSR_SPMPCFG0[11:4];
    assign w_is_addr = csr_addr_i >= CSR_SPMPADDR0 && csr_addr_i < CSR_SPMPADDR0 + 12'd64;
    assign w_illegal = priv_lvl_i == PRIV_U || !(w_is_cfg || w_is_addr) || (w_is_cfg && XLEN == 64 && csr_addr_i[0]);
    assign w_aidx = 6'(csr_addr_i - CSR_SPMPADDR0);
    assign w_aidx_ok = int'(w_aidx) < NR_ENTRIES;

    // Each spmpcfg CSR covers entries 4*n .. 4*n+NB-1 in both RV32 and RV64
    for (genvar k = 0; k < NB; k++) begin : g_lane
        assign w_ent[k] = {1'b0, csr_addr_i[3:0], 2'b00} + 7'(k);
        assign w_ent_ok[k] = int'(w_ent[k]) < NR_ENTRIES;
        spmp_cfg_legalize #(.PLEN(PLEN)) u_leg (
            .i_cfg  (csr_wdata_i[8*k +: 8]),
            .i_addr (spmpaddr_t'(csr_wdata_i)),
            .o_cfg  (w_leg_cfg[k]),
            .o_addr (w_leg_addr[k])
        );
    end

    for (genvar e = 0; e < SPMP_N_ENTRIES; e++) begin : g_out
        assign spmpcfg_o[e] = e < NR_ENTRIES ? r_cfg[e] : '0;
        assign spmpaddr_o[e] = e < NR_ENTRIES ? r_addr[e] : '0;
    end

    always_comb begin
        w_rdata = '0;
        w_chg = 1'b0;
        if (!w_illegal && w_is_cfg) begin
            for (int k = 0; k < NB; k++) begin
                if (w_ent_ok[k]) begin
                    w_rdata[8*k +: 8] = r_cfg[w_ent[k][5:0]];
                    w_chg = w_chg | (csr_we_i && |(r_cfg[w_ent[k][5:0]] ^ w_leg_cfg[k]));
                end
            end
        end else if (!w_illegal && w_aidx_ok) begin
            w_rdata = XLEN'(r_addr[w_aidx]);
            w_chg = csr_we_i && |(r_addr[w_aidx] ^ w_leg_addr[0]);
        end
    end

    always_comb begin
        w_state_nxt = r_state == IDLE ? (w_accept ? RESP : IDLE) :
                      r_state == RESP ? (r_chg ? FLUSH : IDLE) :
                      r_state == FLUSH ? (flush_ack_i ? IDLE : FLUSH) : IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_rdata <= '0;
            r_illegal <= 1'b0;
            r_chg <= 1'b0;
            for (int i = 0; i < SPMP_N_ENTRIES; i++) begin
                r_cfg[i] <= '0;
                r_addr[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_rdata <= w_accept ? w_rdata : '0;
            r_illegal <= w_accept && w_illegal;
            r_chg <= w_accept && w_chg;
            if (w_accept && csr_we_i && !w_illegal) begin
                if (w_is_cfg) begin
                    for (int k = 0; k < NB; k++)
                        if (w_ent_ok[k]) r_cfg[w_ent[k][5:0]] <= w_leg_cfg[k];
                end else if (w_aidx_ok) begin
                    r_addr[w_aidx] <= w_leg_addr[0];
                end
            end
        end
    end
endmodule
